intersection_phase_scheduler: RTL and testbench

- Sequences a two-approach intersection: north-south main road (NS), east-west side road (EW), and a pedestrian crossing.
- Time-shares right-of-way between the EW vehicle sensor and the pedestrian push-button, with NS as the default phase.
- Drives two red/yellow/green lamp sets and a walk lamp, all Moore-decoded from one phase register.
- Time base is an external one-cycle tick strobe, so all durations are in ticks, not clocks.

---
 rtl/intersection_phase_scheduler_if.sv | 28 ++
 rtl/intersection_phase_scheduler.sv | 138 +++++++++++++
 tb/tb_intersection_phase_scheduler.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/intersection_phase_scheduler_if.sv
// Request and lamp bundle between the intersection controller and its environment.
// The master side drives the time base and requests; the slave side is the scheduler.
interface intersection_phase_scheduler_if;
    logic       tick;
    logic       ew_req;
    logic       ped_req;
    logic       ns_red;
    logic       ns_yellow;
    logic       ns_green;
    logic       ew_red;
    logic       ew_yellow;
    logic       ew_green;
    logic       walk;
    logic       ped_pending;
    logic [2:0] phase;

    modport master (
        output tick, ew_req, ped_req,
        input  ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green,
        input  walk, ped_pending, phase
    );

    modport slave (
        input  tick, ew_req, ped_req,
        output ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green,
        output walk, ped_pending, phase
    );
endinterface

// File: rtl/intersection_phase_scheduler.sv
// Two-road intersection scheduler with pedestrian phase; NS is the resting phase.
// All durations count external ticks, and the lamps are a pure decode of the phase register.
module intersection_phase_scheduler #(
    parameter int CW          = 8,
    parameter int T_MIN_GREEN = 10,
    parameter int T_MAX_GREEN = 30,
    parameter int T_YELLOW    = 3,
    parameter int T_ALL_RED   = 2,
    parameter int T_WALK      = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    intersection_phase_scheduler_if.slave  bus
);

    localparam logic [2:0] NS_GREEN  = 3'd0;
    localparam logic [2:0] NS_YELLOW = 3'd1;
    localparam logic [2:0] CLR1      = 3'd2;
    localparam logic [2:0] EW_GREEN  = 3'd3;
    localparam logic [2:0] EW_YELLOW = 3'd4;
    localparam logic [2:0] CLR2      = 3'd5;
    localparam logic [2:0] PED_WALK  = 3'd6;

    // Each threshold is the timer value seen on the tick that ends the interval.
    localparam logic [CW-1:0] TIMER_MAX      = '1;
    localparam logic [CW-1:0] MIN_GREEN_LAST = CW'(T_MIN_GREEN - 1);
    localparam logic [CW-1:0] MAX_GREEN_LAST = CW'(T_MAX_GREEN - 1);
    localparam logic [CW-1:0] YELLOW_LAST    = CW'(T_YELLOW - 1);
    localparam logic [CW-1:0] ALL_RED_LAST   = CW'(T_ALL_RED - 1);
    localparam logic [CW-1:0] WALK_LAST      = CW'(T_WALK - 1);

    logic [2:0]    phase_q, phase_d;
    logic [CW-1:0] timer_q, timer_d;
    logic          ped_pending_q, ped_pending_d;
    logic [6:0]    lamps;

    always_comb begin
        phase_d       = phase_q;
        timer_d       = timer_q;
        ped_pending_d = ped_pending_q | bus.ped_req;

        if (bus.tick && (timer_q != TIMER_MAX)) begin
            timer_d = timer_q + CW'(1);
        end

        case (phase_q)
            NS_GREEN: begin
                if (bus.tick && (bus.ew_req || ped_pending_q) && (timer_q >= MIN_GREEN_LAST)) begin
                    phase_d = NS_YELLOW;
                end
            end
            NS_YELLOW: begin
                if (bus.tick && (timer_q == YELLOW_LAST)) begin
                    phase_d = CLR1;
                end
            end
            CLR1: begin
                // Pedestrians take precedence; a vanished EW request falls back toward NS.
                if (bus.tick && (timer_q == ALL_RED_LAST)) begin
                    if (ped_pending_q) begin
                        phase_d = PED_WALK;
                    end else if (bus.ew_req) begin
                        phase_d = EW_GREEN;
                    end else begin
                        phase_d = CLR2;
                    end
                end
            end
            EW_GREEN: begin
                if (bus.tick && ((timer_q == MAX_GREEN_LAST) ||
                                 (!bus.ew_req && (timer_q >= MIN_GREEN_LAST)))) begin
                    phase_d = EW_YELLOW;
                end
            end
            EW_YELLOW: begin
                if (bus.tick && (timer_q == YELLOW_LAST)) begin
                    phase_d = CLR2;
                end
            end
            CLR2: begin
                if (bus.tick && (timer_q == ALL_RED_LAST)) begin
                    phase_d = NS_GREEN;
                end
            end
            PED_WALK: begin
                if (bus.tick && (timer_q == WALK_LAST)) begin
                    phase_d = CLR2;
                end
            end
            default: phase_d = CLR2;
        endcase

        if (phase_d != phase_q) begin
            timer_d = '0;
        end

        // Entering the walk serves every press latched so far, including one on this clock.
        if ((phase_d == PED_WALK) && (phase_q != PED_WALK)) begin
            ped_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q       <= CLR2;
            timer_q       <= '0;
            ped_pending_q <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            timer_q       <= timer_d;
            ped_pending_q <= ped_pending_d;
        end
    end

    // Lamp order: ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk.
    always_comb begin
        lamps = 7'b100_100_0;
        case (phase_q)
            NS_GREEN:  lamps = 7'b001_100_0;
            NS_YELLOW: lamps = 7'b010_100_0;
            EW_GREEN:  lamps = 7'b100_001_0;
            EW_YELLOW: lamps = 7'b100_010_0;
            PED_WALK:  lamps = 7'b100_100_1;
            default:   lamps = 7'b100_100_0;
        endcase
    end

    assign bus.ns_red      = lamps[6];
    assign bus.ns_yellow   = lamps[5];
    assign bus.ns_green    = lamps[4];
    assign bus.ew_red      = lamps[3];
    assign bus.ew_yellow   = lamps[2];
    assign bus.ew_green    = lamps[1];
    assign bus.walk        = lamps[0];
    assign bus.ped_pending = ped_pending_q;
    assign bus.phase       = phase_q;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed bench for intersection_phase_scheduler: phase durations, request priority,
// gap-out/max-out, tick freeze and async reset, with lamp safety checked every cycle.
module tb_intersection_phase_scheduler;

    localparam logic [2:0] NS_GREEN  = 3'd0;
    localparam logic [2:0] NS_YELLOW = 3'd1;
    localparam logic [2:0] CLR1      = 3'd2;
    localparam logic [2:0] EW_GREEN  = 3'd3;
    localparam logic [2:0] EW_YELLOW = 3'd4;
    localparam logic [2:0] CLR2      = 3'd5;
    localparam logic [2:0] PED_WALK  = 3'd6;

    logic clk;
    logic reset;
    int   check_count;
    int   error_count;

    intersection_phase_scheduler_if bus ();

    intersection_phase_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected lamps {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk} for each phase.
    function automatic logic [6:0] expected_lamps(input logic [2:0] ph);
        case (ph)
            NS_GREEN:  return 7'b0011000;
            NS_YELLOW: return 7'b0101000;
            EW_GREEN:  return 7'b1000010;
            EW_YELLOW: return 7'b1000100;
            PED_WALK:  return 7'b1001001;
            default:   return 7'b1001000;
        endcase
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        assert (observed === expected) else begin
            error_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_state(input string tag, input logic [2:0] exp_phase);
        check_output({tag, "_phase"}, 32'(bus.phase), 32'(exp_phase));
        check_output({tag, "_lamps"},
                     32'({bus.ns_red, bus.ns_yellow, bus.ns_green,
                          bus.ew_red, bus.ew_yellow, bus.ew_green, bus.walk}),
                     32'(expected_lamps(exp_phase)));
    endtask

    task automatic apply_stimulus(input logic t, input logic ew, input logic ped);
        bus.tick    = t;
        bus.ew_req  = ew;
        bus.ped_req = ped;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Counts clock edges until the phase leaves exp_phase; a runaway shows up as a length error.
    task automatic measure_phase(input string tag, input logic [2:0] exp_phase, input int exp_len);
        int cnt;
        check_state(tag, exp_phase);
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while ((bus.phase == exp_phase) && (cnt <= 200));
        check_output({tag, "_len"}, 32'(cnt), 32'(exp_len));
    endtask

    // Lamp safety invariants, sampled mid-cycle whenever out of reset.
    always @(negedge clk) begin
        if (!reset) begin
            check_count++;
            assert ($onehot({bus.ns_red, bus.ns_yellow, bus.ns_green}) &&
                    $onehot({bus.ew_red, bus.ew_yellow, bus.ew_green})) else begin
                error_count++;
                $error("[TB] FAIL one_lamp_per_road: observed ns=%b ew=%b expected one-hot",
                       {bus.ns_red, bus.ns_yellow, bus.ns_green},
                       {bus.ew_red, bus.ew_yellow, bus.ew_green});
            end
            check_count++;
            assert (bus.ns_red || bus.ew_red) else begin
                error_count++;
                $error("[TB] FAIL conflict: observed ns_red=%b ew_red=%b expected one red",
                       bus.ns_red, bus.ew_red);
            end
            check_count++;
            assert (!bus.walk || (bus.ns_red && bus.ew_red)) else begin
                error_count++;
                $error("[TB] FAIL walk_red: observed walk=%b ns_red=%b ew_red=%b expected both red",
                       bus.walk, bus.ns_red, bus.ew_red);
            end
        end
    end

    initial begin
        check_count = 0;
        error_count = 0;

        // Reset, then idle with no requests: NS rests indefinitely.
        reset = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0);
        step(2);
        check_state("reset", CLR2);
        check_output("reset_ped", 32'(bus.ped_pending), 32'd0);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        measure_phase("idle_clr2", CLR2, 2);
        step(100);
        check_state("idle_hold", NS_GREEN);
        check_output("idle_ns_green", 32'(bus.ns_green), 32'd1);
        check_output("idle_ew_red", 32'(bus.ew_red), 32'd1);

        // EW request held from reset: full cycle with EW max-out.
        reset = 1'b1;
        apply_stimulus(1'b1, 1'b1, 1'b0);
        #1;
        check_state("ew_reset", CLR2);
        reset = 1'b0;
        measure_phase("max_clr2a", CLR2, 2);
        measure_phase("max_nsg", NS_GREEN, 10);
        measure_phase("max_nsy", NS_YELLOW, 3);
        measure_phase("max_clr1", CLR1, 2);
        measure_phase("max_ewg", EW_GREEN, 30);
        measure_phase("max_ewy", EW_YELLOW, 3);
        measure_phase("max_clr2b", CLR2, 2);

        // EW gap-out: request drops after 5 ticks of EW green, green still lasts the minimum.
        measure_phase("gap_nsg", NS_GREEN, 10);
        measure_phase("gap_nsy", NS_YELLOW, 3);
        measure_phase("gap_clr1", CLR1, 2);
        check_state("gap_ewg_entry", EW_GREEN);
        step(5);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        measure_phase("gap_ewg_rest", EW_GREEN, 5);
        measure_phase("gap_ewy", EW_YELLOW, 3);
        measure_phase("gap_clr2", CLR2, 2);

        // Pedestrian press during NS green with no EW demand.
        step(3);
        apply_stimulus(1'b1, 1'b0, 1'b1);
        step(1);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_output("ped_latched", 32'(bus.ped_pending), 32'd1);
        measure_phase("ped_nsg_rest", NS_GREEN, 6);
        measure_phase("ped_nsy", NS_YELLOW, 3);
        measure_phase("ped_clr1", CLR1, 2);
        check_output("ped_cleared", 32'(bus.ped_pending), 32'd0);
        check_output("ped_walk_lamp", 32'(bus.walk), 32'd1);
        measure_phase("ped_walk", PED_WALK, 8);
        measure_phase("ped_clr2", CLR2, 2);
        step(20);
        check_state("ped_rest", NS_GREEN);

        // Both requests: walk first, then NS minimum green, then EW.
        apply_stimulus(1'b1, 1'b1, 1'b1);
        step(1);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        check_output("both_ped_latched", 32'(bus.ped_pending), 32'd1);
        measure_phase("both_nsy", NS_YELLOW, 3);
        measure_phase("both_clr1", CLR1, 2);
        measure_phase("both_walk", PED_WALK, 8);
        measure_phase("both_clr2", CLR2, 2);
        measure_phase("both_nsg", NS_GREEN, 10);
        measure_phase("both_nsy2", NS_YELLOW, 3);
        measure_phase("both_clr1b", CLR1, 2);
        measure_phase("both_ewg", EW_GREEN, 30);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        measure_phase("both_ewy", EW_YELLOW, 3);
        measure_phase("both_clr2b", CLR2, 2);

        // Tick held low freezes timer and phase despite demand.
        apply_stimulus(1'b0, 1'b1, 1'b0);
        step(20);
        check_state("freeze", NS_GREEN);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        measure_phase("freeze_nsg", NS_GREEN, 10);
        measure_phase("freeze_nsy", NS_YELLOW, 3);
        measure_phase("freeze_clr1", CLR1, 2);

        // Async reset mid EW green with a pending pedestrian request.
        apply_stimulus(1'b1, 1'b1, 1'b1);
        step(1);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        check_state("pre_reset", EW_GREEN);
        check_output("pre_reset_ped", 32'(bus.ped_pending), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_state("async_reset", CLR2);
        check_output("async_reset_ped", 32'(bus.ped_pending), 32'd0);
        check_output("async_reset_walk", 32'(bus.walk), 32'd0);
        reset = 1'b0;
        measure_phase("post_reset_clr2", CLR2, 2);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
